// File: rtl/diff_edge_serializer_pkg.sv
// Shared constants and state encoding for the circular-difference edge serializer.
package diff_edge_serializer_pkg;

    localparam int WIDTH = 100;
    localparam int IDX_W = 7;
    localparam int CNT_W = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/diff_edge_serializer_lowbit_pri_enc.sv
// Combinational lowest-set-bit priority encoder with a "at most one bit set" flag.
module lowbit_pri_enc
    import diff_edge_serializer_pkg::*;
#(
    parameter int MW = WIDTH,
    parameter int IW = IDX_W
) (
    input  logic [MW-1:0] i_mask,
    output logic [IW-1:0] o_idx,
    output logic          o_single
);

    logic [MW-1:0] w_rest;

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        o_idx = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign w_rest   = i_mask & (i_mask - MW'(1));
    assign o_single = (w_rest == '0);

endmodule

// File: rtl/diff_edge_serializer.sv
// Serialises set-bit indices of a circular neighbour-difference vector, lowest first,
// and reports the per-vector edge count and odd-parity flag when the vector completes.
module diff_edge_serializer
    import diff_edge_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] done_count,
    output logic             done_odd
);

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [CNT_W-1:0] r_done_count;
    logic             r_done_odd;

    logic [IDX_W-1:0] w_idx;
    logic             w_single;
    logic [WIDTH-1:0] w_mask_next;
    logic [CNT_W-1:0] w_cnt_inc;

    lowbit_pri_enc #(
        .MW (WIDTH),
        .IW (IDX_W)
    ) u_enc (
        .i_mask   (r_mask),
        .o_idx    (w_idx),
        .o_single (w_single)
    );

    // Clearing the lowest set bit is the same mask & (mask-1) trick the encoder uses.
    assign w_mask_next = r_mask & (r_mask - WIDTH'(1));
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_done_count <= '0;
            r_done_odd   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mask <= in_diff;
                        r_cnt  <= '0;
                        if (in_diff == '0) begin
                            r_done       <= 1'b1;
                            r_done_count <= '0;
                            r_done_odd   <= 1'b0;
                        end else begin
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_mask <= w_mask_next;
                        r_cnt  <= w_cnt_inc;
                        if (w_single) begin
                            r_state      <= IDLE;
                            r_done       <= 1'b1;
                            r_done_count <= w_cnt_inc;
                            r_done_odd   <= w_cnt_inc[0];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // All outputs decode registers only, so they hold steady under backpressure.
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == EMIT);
    assign out_idx    = w_idx;
    assign out_last   = (r_state == EMIT) && w_single;
    assign done       = r_done;
    assign done_count = r_done_count;
    assign done_odd   = r_done_odd;

endmodule

// File: tb/tb_diff_edge_serializer.sv
// Directed self-checking bench for diff_edge_serializer.
module tb_diff_edge_serializer;
    import diff_edge_serializer_pkg::*;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_diff;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             done;
    logic [CNT_W-1:0] done_count;
    logic             done_odd;

    int n_checks;
    int n_fails;

    diff_edge_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_diff    (in_diff),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done),
        .done_count (done_count),
        .done_odd   (done_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] vec);
        in_valid = 1'b1;
        in_diff  = vec;
        step();
        in_valid = 1'b0;
        in_diff  = '0;
    endtask

    logic [WIDTH-1:0] v;

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_diff   = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_done_odd", done_odd, 0);

        // Zero vector
        send('0);
        chk("t1_out_valid", out_valid, 0);
        chk("t1_done", done, 1);
        chk("t1_done_count", done_count, 0);
        chk("t1_done_odd", done_odd, 0);
        chk("t1_in_ready", in_ready, 1);
        step();
        chk("t1_done_pulse", done, 0);

        // Bits 3 and 97
        v = '0; v[3] = 1'b1; v[97] = 1'b1;
        send(v);
        chk("t2_b0_valid", out_valid, 1);
        chk("t2_b0_idx", out_idx, 3);
        chk("t2_b0_last", out_last, 0);
        chk("t2_b0_in_ready", in_ready, 0);
        step();
        chk("t2_b1_valid", out_valid, 1);
        chk("t2_b1_idx", out_idx, 97);
        chk("t2_b1_last", out_last, 1);
        chk("t2_b1_in_ready", in_ready, 0);
        step();
        chk("t2_end_valid", out_valid, 0);
        chk("t2_end_in_ready", in_ready, 1);
        chk("t2_done", done, 1);
        chk("t2_done_count", done_count, 2);
        chk("t2_done_odd", done_odd, 0);
        step();
        chk("t2_done_pulse", done, 0);
        chk("t2_count_hold", done_count, 2);

        // Wrap pair: bits 0 and 99
        v = '0; v[0] = 1'b1; v[99] = 1'b1;
        send(v);
        chk("t3_b0_idx", out_idx, 0);
        chk("t3_b0_last", out_last, 0);
        step();
        chk("t3_b1_idx", out_idx, 99);
        chk("t3_b1_last", out_last, 1);
        step();
        chk("t3_done", done, 1);
        chk("t3_done_count", done_count, 2);
        chk("t3_done_odd", done_odd, 0);

        // Backpressure mid-vector
        v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
        send(v);
        chk("t4_b0_idx", out_idx, 10);
        step();
        chk("t4_b1_idx", out_idx, 20);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_idx", out_idx, 20);
            chk("t4_hold_last", out_last, 0);
            chk("t4_hold_done", done, 0);
        end
        out_ready = 1'b1;
        step();
        chk("t4_b2_idx", out_idx, 30);
        chk("t4_b2_last", out_last, 1);
        step();
        chk("t4_done", done, 1);
        chk("t4_done_count", done_count, 3);
        chk("t4_done_odd", done_odd, 1);

        // All bits set
        v = '1;
        send(v);
        for (int i = 0; i < WIDTH; i++) begin
            chk("t5_valid", out_valid, 1);
            chk("t5_idx", out_idx, i);
            chk("t5_last", out_last, (i == WIDTH - 1) ? 1 : 0);
            step();
        end
        chk("t5_end_valid", out_valid, 0);
        chk("t5_done", done, 1);
        chk("t5_done_count", done_count, 100);
        chk("t5_done_odd", done_odd, 0);

        // Reset mid-EMIT
        v = '0; v[42] = 1'b1;
        send(v);
        chk("t6_valid", out_valid, 1);
        chk("t6_idx", out_idx, 42);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_done", done, 0);
        step();
        chk("t6_no_done", done, 0);
        chk("t6_no_valid", out_valid, 0);
        v = '0; v[5] = 1'b1;
        send(v);
        chk("t6_b0_valid", out_valid, 1);
        chk("t6_b0_idx", out_idx, 5);
        chk("t6_b0_last", out_last, 1);
        step();
        chk("t6_done", done, 1);
        chk("t6_done_count", done_count, 1);
        chk("t6_done_odd", done_odd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/diff_edge_serializer.md
Name: diff_edge_serializer

Overview:
Consumes a WIDTH-bit circular neighbour-difference vector, where bit i = v[i] ^ v[(i+1) mod WIDTH] and bit WIDTH-1 is the wrap pair. Serialises the index of every set bit, lowest first, over a valid/ready stream. Reports a per-vector summary (edge count, odd-parity error) when the vector completes. Sits directly downstream of the 100-bit neighbour gate stage and feeds the edge-position consumers.

Parameters:
WIDTH, 100, vector width (>=2)
IDX_W, 7, index width = clog2(WIDTH)
CNT_W, 7, count width = clog2(WIDTH+1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  upstream vector valid
in_ready  output  1  block can accept a vector
in_diff  input  WIDTH  circular difference vector
out_valid  output  1  index beat valid
out_ready  input  1  downstream accepts beat
out_idx  output  IDX_W  index of current set bit
out_last  output  1  final beat of this vector
done  output  1  one-cycle pulse, vector finished
done_count  output  CNT_W  number of set bits in finished vector
done_odd  output  1  count was odd (illegal for a true circular diff)

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on rising clk; reset has priority over every other event.
- Reset values: state=IDLE, mask=0, cnt=0, out_valid=0, out_idx=0, out_last=0, done=0, done_count=0, done_odd=0, in_ready=1.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: mask<=in_diff, cnt<=0.
  - If in_diff==0: stay IDLE; next cycle done=1, done_count=0, done_odd=0.
  - Otherwise go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = position of the lowest set bit of mask. out_last = (mask has exactly one bit set).
  - Both are functions of registers only, so they stay stable while out_ready=0.
  - On out_valid&&out_ready: clear that bit in mask, cnt<=cnt+1.
  - If out_last: go to IDLE; next cycle done=1, done_count=cnt+1, done_odd=bit0 of (cnt+1).
- Timing:
  - Latency: vector accepted in cycle N -> first out_valid in N+1.
  - With out_ready held at 1: one beat per cycle.
  - done pulses in the cycle after the last handshake. That cycle is IDLE with in_ready=1, so there is one bubble between vectors.
- Boundaries:
  - done_count/done_odd hold their values until the next done.
  - in_valid while in EMIT is ignored; upstream must hold the vector.
  - The wrap bit WIDTH-1 is emitted last when set. Index WIDTH-1 never overflows IDX_W.
  - All WIDTH bits set: WIDTH beats, done_count=WIDTH.
  - Reset mid-EMIT: the vector is discarded, out_valid=0 in the following cycle, no done pulse.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

Decomposition:
- Shared package holds:
  - WIDTH, IDX_W, CNT_W constants.
  - State enum {IDLE, EMIT}.
- One sub-module, lowbit_pri_enc: WIDTH-bit mask in -> IDX_W index of lowest set bit, plus a "single" flag (mask & (mask-1))==0. Purely combinational.
- The FSM, mask and count registers live in diff_edge_serializer.

Test Plan:
1. in_diff=0, in_valid 1 cycle -> no out_valid; done=1 one cycle later, done_count=0, done_odd=0.
2. Bits 3 and 97 set, out_ready=1 -> beats idx=3 (last=0), idx=97 (last=1); done_count=2, done_odd=0; in_ready=0 for exactly 2 cycles.
3. Wrap case, bits 0 and 99 set -> idx=0 then idx=99 (last=1); done_count=2.
4. Backpressure: bits 10,20,30 set, out_ready low for 5 cycles mid-vector -> out_idx held at 20, no beat lost or duplicated; done_count=3, done_odd=1.
5. All 100 bits set, out_ready=1 -> 100 consecutive beats idx 0..99, last only on 99; done_count=100, done_odd=0.
6. Single bit 42 set, reset asserted while out_valid=1 -> out_valid=0 and in_ready=1 next cycle, no done pulse; a following vector with bit 5 set emits idx=5 cleanly.
